// File: rtl/alu_pkg.sv
// Shared opcode encodings and illegal-opcode boundary for the ALU and its arbiter.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_SLT  = 4'b0010,
      OP_SLTU = 4'b0011,
      OP_SLL  = 4'b0100,
      OP_XOR  = 4'b0101,
      OP_SRL  = 4'b0110,
      OP_SRA  = 4'b0111,
      OP_OR   = 4'b1000,
      OP_AND  = 4'b1001,
      OP_NOP  = 4'b1010,
      OP_BGE  = 4'b1011
   } alu_op_e;

   // Opcodes at or above this value are undefined.
   localparam logic [3:0] OP_ILLEGAL_MIN = 4'b1100;

   function automatic logic is_illegal(input logic [3:0] op);
      return (op >= OP_ILLEGAL_MIN);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational 32-bit ALU: opcode and operands in, result and flags out.
module alu_core
   import alu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        zero,
   output logic        overflow,
   output logic        illegal
);

   logic [4:0]  shamt;
   logic [31:0] sum;
   logic [31:0] diff;

   assign shamt = b[4:0];
   assign sum   = a + b;
   assign diff  = a - b;

   // Opcode decode; illegal and nop opcodes fall through to a zero result.
   always_comb begin
      result   = '0;
      overflow = 1'b0;
      illegal  = is_illegal(op);
      case (op)
         OP_ADD: begin
            result   = sum;
            overflow = (a[31] == b[31]) && (sum[31] != a[31]);
         end
         OP_SUB: begin
            result   = diff;
            overflow = (a[31] != b[31]) && (diff[31] != a[31]);
         end
         OP_SLT:  result = {31'b0, ($signed(a) < $signed(b))};
         OP_SLTU: result = {31'b0, (a < b)};
         OP_SLL:  result = a << shamt;
         OP_XOR:  result = a ^ b;
         OP_SRL:  result = a >> shamt;
         OP_SRA:  result = $unsigned($signed(a) >>> shamt);
         OP_OR:   result = a | b;
         OP_AND:  result = a & b;
         OP_NOP:  result = '0;
         OP_BGE:  result = {31'b0, ($signed(a) >= $signed(b))};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: grants one requester per cycle and
// registers the granted operation's result one cycle later.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned RR_EN    = 1,
   parameter int unsigned MAX_WAIT = 4
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        resp_valid,
   output logic        resp_id,
   output logic [31:0] resp_result,
   output logic        resp_zero,
   output logic        resp_overflow,
   output logic        resp_illegal
);

   logic        last_grant;
   logic [3:0]  wait_cnt;
   logic        grant0;
   logic        grant1;
   logic        xfer;
   logic [3:0]  sel_op;
   logic [31:0] sel_a;
   logic [31:0] sel_b;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        alu_overflow;
   logic        alu_illegal;

   logic        valid_q;
   logic        id_q;
   logic [31:0] result_q;
   logic        zero_q;
   logic        overflow_q;
   logic        illegal_q;

   // Grant selection: lone requester wins; contention resolved by mode.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst) begin
         if (req0_valid && !req1_valid) begin
            grant0 = 1'b1;
         end else if (!req0_valid && req1_valid) begin
            grant1 = 1'b1;
         end else if (req0_valid && req1_valid) begin
            if (RR_EN != 0) begin
               grant0 = last_grant;
               grant1 = !last_grant;
            end else if (wait_cnt == 4'(MAX_WAIT)) begin
               grant1 = 1'b1;
            end else begin
               grant0 = 1'b1;
            end
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign xfer       = grant0 | grant1;
   assign sel_op     = grant1 ? req1_op : req0_op;
   assign sel_a      = grant1 ? req1_a  : req0_a;
   assign sel_b      = grant1 ? req1_b  : req0_b;

   alu_core u_alu_core (
      .op       (sel_op),
      .a        (sel_a),
      .b        (sel_b),
      .result   (alu_result),
      .zero     (alu_zero),
      .overflow (alu_overflow),
      .illegal  (alu_illegal)
   );

   // Arbitration state and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         wait_cnt   <= '0;
         valid_q    <= 1'b0;
         id_q       <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         if (xfer) begin
            last_grant <= grant1;
         end
         if (!req1_valid || grant1) begin
            wait_cnt <= '0;
         end else if (wait_cnt != 4'hF) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
         valid_q <= xfer;
         if (xfer) begin
            id_q       <= grant1;
            result_q   <= alu_result;
            zero_q     <= alu_zero;
            overflow_q <= alu_overflow;
            illegal_q  <= alu_illegal;
         end
      end
   end

   // Reset forces the response outputs low immediately, so a response
   // registered in the cycle before reset is never seen.
   assign resp_valid    = valid_q    & ~rst;
   assign resp_id       = id_q       & ~rst;
   assign resp_result   = rst ? '0 : result_q;
   assign resp_zero     = zero_q     & ~rst;
   assign resp_overflow = overflow_q & ~rst;
   assign resp_illegal  = illegal_q  & ~rst;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: one round-robin and one
// fixed-priority instance driven by the same stimulus.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0;
   logic [3:0]  req0_op = '0;
   logic [31:0] req0_a = '0;
   logic [31:0] req0_b = '0;
   logic        req1_valid = 1'b0;
   logic [3:0]  req1_op = '0;
   logic [31:0] req1_a = '0;
   logic [31:0] req1_b = '0;

   logic        rr_ready0, rr_ready1, rr_valid, rr_id, rr_zero, rr_ovf, rr_ill;
   logic [31:0] rr_result;
   logic        fp_ready0, fp_ready1, fp_valid, fp_id, fp_zero, fp_ovf, fp_ill;
   logic [31:0] fp_result;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      logic        ovf;
      logic        ill;
   } vec_t;

   vec_t vecs [15];

   alu_arbiter #(.RR_EN(1), .MAX_WAIT(4)) dut_rr (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(rr_ready0), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(rr_ready1), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .resp_valid(rr_valid), .resp_id(rr_id), .resp_result(rr_result),
      .resp_zero(rr_zero), .resp_overflow(rr_ovf), .resp_illegal(rr_ill)
   );

   alu_arbiter #(.RR_EN(0), .MAX_WAIT(4)) dut_fp (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(fp_ready0), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(fp_ready1), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .resp_valid(fp_valid), .resp_id(fp_id), .resp_result(fp_result),
      .resp_zero(fp_zero), .resp_overflow(fp_ovf), .resp_illegal(fp_ill)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         fails = fails + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [9:0] fp_grant1;
      logic       prev_rr;
      logic       prev_fp;

      // Expected fixed-priority grant-to-1 pattern (bit i = cycle i).
      fp_grant1 = 10'b10_0001_0000;

      vecs[0]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{OP_SLL,  32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{OP_XOR,  32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{OP_SRL,  32'h80000000, 32'h00000023, 32'h10000000, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{OP_OR,   32'h00FF0000, 32'h0000FF00, 32'h00FFFF00, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{OP_AND,  32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{OP_NOP,  32'h00001234, 32'h00005678, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{OP_BGE,  32'hFFFFFFFB, 32'hFFFFFFFB, 32'h00000001, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{OP_BGE,  32'hFFFFFFFB, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{4'b1100, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[13] = '{4'b1111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[14] = '{OP_ADD,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};

      // Under reset: a valid request is not granted, response outputs are zero.
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      @(negedge clk); #1;
      chk("rst_ready0", rr_ready0, 1'b0);
      chk("rst_ready1", rr_ready1, 1'b0);
      chk("rst_valid",  rr_valid,  1'b0);
      chk("rst_result", rr_result, 32'h0);
      chk("rst_id",     rr_id,     1'b0);
      chk("rst_fp_ready0", fp_ready0, 1'b0);

      // Lone req0 add with signed overflow.
      do_reset();
      req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h7FFFFFFF; req0_b = 32'h00000001;
      #1;
      chk("add_ready0", rr_ready0, 1'b1);
      chk("add_ready1", rr_ready1, 1'b0);
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      chk("add_valid",  rr_valid,  1'b1);
      chk("add_id",     rr_id,     1'b0);
      chk("add_result", rr_result, 32'h80000000);
      chk("add_ovf",    rr_ovf,    1'b1);
      chk("add_zero",   rr_zero,   1'b0);
      @(negedge clk); #1;
      chk("idle_valid", rr_valid,  1'b0);
      chk("idle_hold",  rr_result, 32'h80000000);

      // Contention: round-robin alternates, fixed priority forces req1 at MAX_WAIT.
      do_reset();
      req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 32'h5;          req0_b = 32'h7;
      req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 32'hF0F0F0F0;   req1_b = 32'h0FF00FF0;
      prev_rr = 1'b0;
      prev_fp = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("rr_ready0_c%0d", i), rr_ready0, (i % 2 == 0));
         chk($sformatf("rr_ready1_c%0d", i), rr_ready1, (i % 2 == 1));
         chk($sformatf("fp_ready1_c%0d", i), fp_ready1, fp_grant1[i]);
         chk($sformatf("fp_ready0_c%0d", i), fp_ready0, !fp_grant1[i]);
         if (i > 0) begin
            chk($sformatf("rr_id_c%0d", i), rr_id, prev_rr);
            chk($sformatf("rr_res_c%0d", i), rr_result, prev_rr ? 32'hFF00FF00 : 32'hFFFFFFFE);
            chk($sformatf("fp_id_c%0d", i), fp_id, prev_fp);
         end
         prev_rr = (i % 2 == 1);
         prev_fp = fp_grant1[i];
         @(negedge clk);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk("rr_id_last", rr_id, 1'b1);
      chk("fp_id_last", fp_id, 1'b1);
      chk("fp_res_last", fp_result, 32'hFF00FF00);

      // req1 arithmetic shift and illegal opcode.
      do_reset();
      req1_valid = 1'b1; req1_op = OP_SRA; req1_a = 32'h80000000; req1_b = 32'h00000024;
      #1;
      chk("sra_ready1", rr_ready1, 1'b1);
      @(negedge clk);
      req1_op = 4'b1101; req1_a = 32'h12345678; req1_b = 32'h9;
      #1;
      chk("sra_id",     rr_id,     1'b1);
      chk("sra_result", rr_result, 32'hF8000000);
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      chk("ill_valid",  rr_valid,  1'b1);
      chk("ill_result", rr_result, 32'h0);
      chk("ill_zero",   rr_zero,   1'b1);
      chk("ill_flag",   rr_ill,    1'b1);
      chk("ill_ovf",    rr_ovf,    1'b0);

      // Back-to-back opcode table on req0 at full throughput.
      do_reset();
      for (int i = 0; i <= 15; i++) begin
         if (i < 15) begin
            req0_valid = 1'b1;
            req0_op = vecs[i].op; req0_a = vecs[i].a; req0_b = vecs[i].b;
         end else begin
            req0_valid = 1'b0;
         end
         #1;
         if (i < 15) chk($sformatf("tbl_ready_%0d", i), rr_ready0, 1'b1);
         if (i > 0) begin
            chk($sformatf("tbl_valid_%0d", i - 1), rr_valid,  1'b1);
            chk($sformatf("tbl_res_%0d",   i - 1), rr_result, vecs[i-1].res);
            chk($sformatf("tbl_zero_%0d",  i - 1), rr_zero,   vecs[i-1].zero);
            chk($sformatf("tbl_ovf_%0d",   i - 1), rr_ovf,    vecs[i-1].ovf);
            chk($sformatf("tbl_ill_%0d",   i - 1), rr_ill,    vecs[i-1].ill);
         end
         @(negedge clk);
      end

      // Reset right after a transfer discards its response.
      do_reset();
      req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h1; req0_b = 32'h2;
      #1;
      chk("mid_ready0", rr_ready0, 1'b1);
      @(negedge clk);
      rst = 1'b1; req1_valid = 1'b1;
      #1;
      chk("mid_valid_n1",  rr_valid,  1'b0);
      chk("mid_result_n1", rr_result, 32'h0);
      chk("mid_ready0_n1", rr_ready0, 1'b0);
      chk("mid_ready1_n1", rr_ready1, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_valid_n2",  rr_valid,  1'b0);
      chk("mid_rr_first",  rr_ready0, 1'b1);
      chk("mid_fp_first",  fp_ready0, 1'b1);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      chk("mid_after_valid",  rr_valid,  1'b1);
      chk("mid_after_id",     rr_id,     1'b0);
      chk("mid_after_result", rr_result, 32'h3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
